// File: rtl/rpcd_pkg.sv
// rpcd_pkg: shared channel geometry, grant-mux state encoding and helpers
// for the rpcd arbiter slice.
package rpcd_pkg;

    localparam int NCH = 8;
    localparam int CHW = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} rpcd_gm_state_t;

    function automatic logic [NCH-1:0] onehot8(input logic [CHW-1:0] idx);
        logic [NCH-1:0] r_v;
        r_v = '0;
        r_v[idx] = 1'b1;
        return r_v;
    endfunction

endpackage

// File: rtl/rpcd_grant_mux.sv
// rpcd_grant_mux: captures the rpcd arbiter's winning request, issues it on one
// shared valid/ready port and routes completion/response back to its channel.
module rpcd_grant_mux
    import rpcd_pkg::*;
#(
    parameter int DW     = 64,
    parameter int RW     = 32,
    parameter bit RSP_EN = 1'b1,
    parameter int TMO    = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    REQ,
    input  logic [NCH*DW-1:0] DIN,
    input  logic [CHW-1:0]    CSEL,
    output logic              ARB_ENA,
    output logic [NCH-1:0]    ACK,
    output logic              OUT_VALID,
    output logic [DW-1:0]     OUT_DATA,
    output logic [CHW-1:0]    OUT_CHAN,
    input  logic              OUT_READY,
    input  logic              RSP_VALID,
    input  logic [RW-1:0]     RSP_DATA,
    output logic [NCH-1:0]    DONE,
    output logic              ERR,
    output logic [RW-1:0]     RDATA
);

    localparam int CW = $clog2(TMO + 1);

    rpcd_gm_state_t r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [DW-1:0]  r_out_data;
    logic [CHW-1:0] r_out_chan;
    logic [NCH-1:0] r_ack, r_done;
    logic           r_err;
    logic [RW-1:0]  r_rdata;
    logic           w_accept, w_rsp, w_tmo, w_fin;

    // Arbiter priority only advances on an actual grant, so it freezes while busy.
    assign ARB_ENA   = (r_state == IDLE) && |REQ;
    assign OUT_VALID = (r_state == ISSUE);
    assign w_accept  = (r_state == ISSUE) && OUT_READY;
    assign w_rsp     = (r_state == WAIT_RSP) && RSP_VALID;
    assign w_tmo     = (r_state == WAIT_RSP) && !RSP_VALID && (r_cnt == CW'(TMO - 1));
    assign w_fin     = w_rsp || w_tmo || (w_accept && !RSP_EN);

    assign ACK      = r_ack;
    assign OUT_DATA = r_out_data;
    assign OUT_CHAN = r_out_chan;
    assign DONE     = r_done;
    assign ERR      = r_err;
    assign RDATA    = r_rdata;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = |REQ ? ISSUE : IDLE;
            ISSUE:    w_next = !OUT_READY ? ISSUE : (RSP_EN ? WAIT_RSP : IDLE);
            WAIT_RSP: w_next = (RSP_VALID || w_tmo) ? IDLE : WAIT_RSP;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_chan <= '0;
            r_ack      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ack  <= ARB_ENA ? onehot8(CSEL) : '0;
            r_done <= w_fin ? onehot8(r_out_chan) : '0;
            r_err  <= w_tmo;
            r_cnt  <= (r_state == WAIT_RSP) ? r_cnt + CW'(1) : '0;
            if (ARB_ENA) begin
                r_out_data <= DIN[CSEL*DW +: DW];
                r_out_chan <= CSEL;
            end
            if (w_rsp) r_rdata <= RSP_DATA;
        end
    end

endmodule

// File: tb/tb_rpcd_grant_mux.sv
// tb_rpcd_grant_mux: scoreboard bench for rpcd_grant_mux with a behavioural
// rotating-priority arbiter standing in for rpcd.
module tb_rpcd_grant_mux;
    import rpcd_pkg::*;

    localparam int DW = 64;
    localparam int RW = 32;

    typedef struct {logic [7:0] ack; logic [2:0] chan; logic [DW-1:0] data;} ack_t;
    typedef struct {logic [7:0] done; logic err; logic [RW-1:0] rdata;} done_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        req = '0, req_p = '0;
    logic [8*DW-1:0]   din = '0;
    logic              out_ready = 1'b0, rsp_valid = 1'b0;
    logic [RW-1:0]     rsp_data = '0;
    logic [2:0]        csel, csel_p, ptr, ptr_p;

    logic              arb_ena, out_valid, err;
    logic [7:0]        ack, done;
    logic [DW-1:0]     out_data;
    logic [2:0]        out_chan;
    logic [RW-1:0]     rdata;

    logic              arb_ena_p, out_valid_p, err_p;
    logic [7:0]        ack_p, done_p;
    logic [DW-1:0]     out_data_p;
    logic [2:0]        out_chan_p;
    logic [RW-1:0]     rdata_p;

    ack_t              ack_q[$];
    done_t             done_q[$];
    int                total = 0;
    int                bad = 0;
    logic [RW-1:0]     last_rdata = '0;

    always #5 clk = ~clk;

    function automatic logic [2:0] arb(input logic [7:0] r, input logic [2:0] p);
        arb = p;
        for (int i = 7; i >= 0; i--) if (r[3'(p + 3'(i))]) arb = 3'(p + 3'(i));
    endfunction

    assign csel   = arb(req, ptr);
    assign csel_p = arb(req_p, ptr_p);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            ptr_p <= '0;
        end else begin
            if (arb_ena)   ptr   <= csel + 3'd1;
            if (arb_ena_p) ptr_p <= csel_p + 3'd1;
        end
    end

    rpcd_grant_mux #(.DW(DW), .RW(RW), .RSP_EN(1'b1), .TMO(4)) u_dut (
        .CLK(clk), .RST(rst), .REQ(req), .DIN(din), .CSEL(csel), .ARB_ENA(arb_ena),
        .ACK(ack), .OUT_VALID(out_valid), .OUT_DATA(out_data), .OUT_CHAN(out_chan),
        .OUT_READY(out_ready), .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
        .DONE(done), .ERR(err), .RDATA(rdata)
    );

    rpcd_grant_mux #(.DW(DW), .RW(RW), .RSP_EN(1'b0), .TMO(255)) u_pst (
        .CLK(clk), .RST(rst), .REQ(req_p), .DIN(din), .CSEL(csel_p), .ARB_ENA(arb_ena_p),
        .ACK(ack_p), .OUT_VALID(out_valid_p), .OUT_DATA(out_data_p), .OUT_CHAN(out_chan_p),
        .OUT_READY(out_ready), .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
        .DONE(done_p), .ERR(err_p), .RDATA(rdata_p)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ack, done, err, out_valid, arb_ena} !== '0) begin
            bad++;
            $display("FAIL reset_ctl got ack=%h done=%h err=%b ov=%b ena=%b exp all 0", ack, done, err, out_valid, arb_ena);
        end
        total++;
        if ({out_data, out_chan, rdata} !== '0) begin
            bad++;
            $display("FAIL reset_data got data=%h chan=%0d rdata=%h exp 0", out_data, out_chan, rdata);
        end
        total++;
        if ({ack_p, done_p, err_p, out_valid_p, rdata_p} !== '0) begin
            bad++;
            $display("FAIL reset_posted got ack=%h done=%h err=%b ov=%b rdata=%h exp 0", ack_p, done_p, err_p, out_valid_p, rdata_p);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_round_robin;
        ack_t  a;
        done_t d;
        int    k = 0;
        for (int n = 0; n < 8; n++) din[n*DW +: DW] = 64'h0123_4567_0000_0000 + 64'(n) * 64'h1_0001;
        for (int i = 0; i < 9; i++) begin
            ack_q.push_back('{onehot8(3'(i % 8)), 3'(i % 8), din[(i % 8)*DW +: DW]});
            done_q.push_back('{onehot8(3'(i % 8)), 1'b0, 32'hBEEF_0000 + 32'(i)});
        end
        req = 8'hFF;
        out_ready = 1'b1;
        rsp_valid = 1'b1;
        for (int c = 0; c < 80 && done_q.size() != 0; c++) begin
            step();
            if (ack != 0) begin
                total++;
                if (ack_q.size() == 0) begin
                    bad++;
                    $display("FAIL rr_extra_ack got=%h exp none", ack);
                end else begin
                    a = ack_q.pop_front();
                    if (ack !== a.ack || out_chan !== a.chan || out_data !== a.data) begin
                        bad++;
                        $display("FAIL rr_grant got ack=%h chan=%0d data=%h exp ack=%h chan=%0d data=%h", ack, out_chan, out_data, a.ack, a.chan, a.data);
                    end
                end
                rsp_data = 32'hBEEF_0000 + 32'(k);
                k++;
                if (ack_q.size() == 0) req = '0;
            end
            if (done != 0) begin
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL rr_extra_done got=%h exp none", done);
                end else begin
                    d = done_q.pop_front();
                    if (done !== d.done || err !== d.err || rdata !== d.rdata) begin
                        bad++;
                        $display("FAIL rr_done got done=%h err=%b rdata=%h exp done=%h err=%b rdata=%h", done, err, rdata, d.done, d.err, d.rdata);
                    end
                    last_rdata = d.rdata;
                end
            end
        end
        total++;
        if (done_q.size() != 0 || ack_q.size() != 0) begin
            bad++;
            $display("FAIL rr_timeout got pending acks=%0d dones=%0d exp 0", ack_q.size(), done_q.size());
        end
        ack_q.delete();
        done_q.delete();
        req = '0;
        rsp_valid = 1'b0;
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_single;
        ack_t  a;
        done_t d;
        din[2*DW +: DW] = 64'hA5A5;
        req = 8'h04;
        out_ready = 1'b1;
        rsp_valid = 1'b0;
        ack_q.push_back('{8'h04, 3'd2, 64'hA5A5});
        done_q.push_back('{8'h04, 1'b0, 32'h1234});
        #1;
        total++;
        if (arb_ena !== 1'b1) begin
            bad++;
            $display("FAIL single_ena got=%b exp=1", arb_ena);
        end
        step();
        a = ack_q.pop_front();
        total++;
        if (ack !== a.ack || out_valid !== 1'b1 || out_data !== a.data || out_chan !== a.chan) begin
            bad++;
            $display("FAIL single_issue got ack=%h ov=%b data=%h chan=%0d exp ack=%h ov=1 data=%h chan=%0d", ack, out_valid, out_data, out_chan, a.ack, a.data, a.chan);
        end
        req = '0;
        din[2*DW +: DW] = 64'hFFFF_0000;
        step();
        total++;
        if (out_valid !== 1'b0 || done !== 8'h00 || ack !== 8'h00) begin
            bad++;
            $display("FAIL single_wait got ov=%b done=%h ack=%h exp 0 0 0", out_valid, done, ack);
        end
        step();
        rsp_valid = 1'b1;
        rsp_data = 32'h1234;
        step();
        rsp_valid = 1'b0;
        d = done_q.pop_front();
        total++;
        if (done !== d.done || err !== d.err || rdata !== d.rdata) begin
            bad++;
            $display("FAIL single_done got done=%h err=%b rdata=%h exp done=%h err=%b rdata=%h", done, err, rdata, d.done, d.err, d.rdata);
        end
        last_rdata = d.rdata;
        step();
        total++;
        if (done !== 8'h00 || ack !== 8'h00 || rdata !== last_rdata) begin
            bad++;
            $display("FAIL single_pulse got done=%h ack=%h rdata=%h exp 0 0 %h", done, ack, rdata, last_rdata);
        end
    endtask

    task automatic test_backpressure;
        ack_t  a;
        done_t d;
        din[4*DW +: DW] = 64'hFEED_FACE_0000_0044;
        req = 8'h10;
        out_ready = 1'b0;
        ack_q.push_back('{8'h10, 3'd4, 64'hFEED_FACE_0000_0044});
        done_q.push_back('{8'h10, 1'b0, 32'h7777_0001});
        step();
        a = ack_q.pop_front();
        total++;
        if (ack !== a.ack || out_data !== a.data || out_chan !== a.chan) begin
            bad++;
            $display("FAIL bp_ack got ack=%h data=%h chan=%0d exp ack=%h data=%h chan=%0d", ack, out_data, out_chan, a.ack, a.data, a.chan);
        end
        req = 8'h01;
        din[4*DW +: DW] = 64'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_data !== a.data || arb_ena !== 1'b0 || ack !== 8'h00) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got ov=%b data=%h ena=%b ack=%h exp ov=1 data=%h ena=0 ack=0", i, out_valid, out_data, arb_ena, ack, a.data);
            end
        end
        req = '0;
        out_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data = 32'h7777_0001;
        step();
        total++;
        if (done !== 8'h00 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept got done=%h ov=%b exp 0 0", done, out_valid);
        end
        step();
        d = done_q.pop_front();
        total++;
        if (done !== d.done || err !== d.err || rdata !== d.rdata) begin
            bad++;
            $display("FAIL bp_done got done=%h err=%b rdata=%h exp done=%h err=%b rdata=%h", done, err, rdata, d.done, d.err, d.rdata);
        end
        last_rdata = d.rdata;
        rsp_valid = 1'b0;
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_timeout;
        done_t d;
        din[5*DW +: DW] = 64'h5555_0000_0000_0005;
        req = 8'h20;
        out_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_data = 32'hDEAD_DEAD;
        done_q.push_back('{8'h20, 1'b1, last_rdata});
        step();
        total++;
        if (ack !== 8'h20 || out_chan !== 3'd5) begin
            bad++;
            $display("FAIL tmo_ack got ack=%h chan=%0d exp ack=20 chan=5", ack, out_chan);
        end
        req = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (done !== 8'h00 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL tmo_wait cyc=%0d got done=%h ov=%b exp 0 0", i, done, out_valid);
            end
            step();
        end
        d = done_q.pop_front();
        total++;
        if (done !== d.done || err !== d.err || rdata !== d.rdata) begin
            bad++;
            $display("FAIL tmo_done got done=%h err=%b rdata=%h exp done=%h err=%b rdata=%h", done, err, rdata, d.done, d.err, d.rdata);
        end
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        total++;
        if (done !== 8'h00 || err !== 1'b0 || rdata !== last_rdata || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL tmo_stray got done=%h err=%b rdata=%h ov=%b exp 0 0 %h 0", done, err, rdata, out_valid, last_rdata);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_posted;
        ack_t  a;
        done_t d;
        din[7*DW +: DW] = 64'h7777_0000_0000_0080;
        rsp_valid = 1'b1;
        rsp_data = 32'h9999_9999;
        out_ready = 1'b0;
        req_p = 8'h80;
        ack_q.push_back('{8'h80, 3'd7, 64'h7777_0000_0000_0080});
        done_q.push_back('{8'h80, 1'b0, 32'h0});
        #1;
        total++;
        if (arb_ena_p !== 1'b1) begin
            bad++;
            $display("FAIL post_ena got=%b exp=1", arb_ena_p);
        end
        step();
        a = ack_q.pop_front();
        total++;
        if (ack_p !== a.ack || out_valid_p !== 1'b1 || out_chan_p !== a.chan || out_data_p !== a.data) begin
            bad++;
            $display("FAIL post_issue got ack=%h ov=%b chan=%0d data=%h exp ack=%h ov=1 chan=%0d data=%h", ack_p, out_valid_p, out_chan_p, out_data_p, a.ack, a.chan, a.data);
        end
        req_p = '0;
        step();
        total++;
        if (done_p !== 8'h00 || out_valid_p !== 1'b1) begin
            bad++;
            $display("FAIL post_hold got done=%h ov=%b exp 0 1", done_p, out_valid_p);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        d = done_q.pop_front();
        total++;
        if (done_p !== d.done || err_p !== d.err || rdata_p !== d.rdata) begin
            bad++;
            $display("FAIL post_done got done=%h err=%b rdata=%h exp done=%h err=%b rdata=%h", done_p, err_p, rdata_p, d.done, d.err, d.rdata);
        end
        step();
        total++;
        if (done_p !== 8'h00 || out_valid_p !== 1'b0 || rdata_p !== 32'h0 || done !== 8'h00) begin
            bad++;
            $display("FAIL post_idle got done=%h ov=%b rdata=%h main_done=%h exp 0 0 0 0", done_p, out_valid_p, rdata_p, done);
        end
        rsp_valid = 1'b0;
    endtask

    task automatic test_async_reset;
        done_t d;
        din[3*DW +: DW] = 64'h3333_3333_3333_3333;
        req = 8'h08;
        out_ready = 1'b1;
        rsp_valid = 1'b0;
        step();
        total++;
        if (ack !== 8'h08) begin
            bad++;
            $display("FAIL ar_ack got=%h exp=08", ack);
        end
        req = '0;
        step();
        #2 rst = 1'b0;
        #1;
        total++;
        if ({ack, done, err, out_valid, out_data, out_chan, rdata} !== '0) begin
            bad++;
            $display("FAIL ar_clear got ack=%h done=%h err=%b ov=%b data=%h chan=%0d rdata=%h exp all 0", ack, done, err, out_valid, out_data, out_chan, rdata);
        end
        step();
        total++;
        if (done !== 8'h00 || ack !== 8'h00) begin
            bad++;
            $display("FAIL ar_held got done=%h ack=%h exp 0 0", done, ack);
        end
        rst = 1'b1;
        din[0*DW +: DW] = 64'h0101_0101_0101_0101;
        rsp_data = 32'h0101_0101;
        rsp_valid = 1'b1;
        req = 8'h01;
        done_q.push_back('{8'h01, 1'b0, 32'h0101_0101});
        step();
        total++;
        if (ack !== 8'h01 || out_chan !== 3'd0 || out_data !== 64'h0101_0101_0101_0101) begin
            bad++;
            $display("FAIL ar_regrant got ack=%h chan=%0d data=%h exp 01 0 0101010101010101", ack, out_chan, out_data);
        end
        req = '0;
        step();
        step();
        d = done_q.pop_front();
        total++;
        if (done !== d.done || err !== d.err || rdata !== d.rdata) begin
            bad++;
            $display("FAIL ar_done got done=%h err=%b rdata=%h exp done=%h err=%b rdata=%h", done, err, rdata, d.done, d.err, d.rdata);
        end
        rsp_valid = 1'b0;
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_timeout();
        test_posted();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
